fetch_unit: RTL

Instruction fetch sequencer sitting directly upstream of the instruction ROM. Owns the program counter, generates the ROM's `oeb` fetch strobe, captures the returned instruction into an instruction register, and presents it downstream with a valid/ack handshake. Also handles branch redirects and a sticky halt.

---
 rtl/fetch_unit.sv | 80 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives the ROM strobe and address, captures the
// returned word into ir and hands it downstream with a valid/ack handshake.
//
// state | meaning
// IDLE  | waiting for stall and halted to clear before starting a fetch
// FETCH | oeb high for one cycle, ROM reads at pc
// LATCH | ROM output settling, captured into ir on exit
// VALID | ir presented downstream until ir_ack
module fetch_unit #(
   parameter int Awidth = 3,
   parameter int Dwidth = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              oeb,
   output logic [Awidth-1:0] pc,
   input  logic [Dwidth-1:0] inst,
   output logic [Dwidth-1:0] ir,
   output logic              ir_valid,
   input  logic              ir_ack,
   input  logic              branch_en,
   input  logic [Awidth-1:0] branch_target,
   input  logic              stall,
   input  logic              halt,
   output logic              halted
);

   typedef enum logic [1:0] {IDLE, FETCH, LATCH, VALID} state_t;

   state_t            state, state_next;
   logic [Awidth-1:0] pc_next;
   logic [Dwidth-1:0] ir_next;
   logic              ir_valid_next;

   always_comb begin
      state_next    = state;
      pc_next       = pc;
      ir_next       = ir;
      ir_valid_next = ir_valid;
      case (state)
         IDLE: begin
            if (!stall && !halted) state_next = FETCH;
         end
         FETCH: state_next = LATCH;
         LATCH: begin
            state_next    = VALID;
            ir_next       = inst;
            ir_valid_next = 1'b1;
         end
         VALID: begin
            if (ir_ack) begin
               ir_valid_next = 1'b0;
               pc_next       = branch_en ? branch_target : pc + 1'b1;
               // a halt arriving on the ack edge itself must already block the next fetch
               state_next    = (!stall && !halted && !halt) ? FETCH : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= '0;
         oeb      <= 1'b0;
         ir       <= '0;
         ir_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         oeb      <= (state_next == FETCH);
         ir       <= ir_next;
         ir_valid <= ir_valid_next;
         halted   <= halted | halt;
      end
   end

endmodule
